gemm_issue_ctrl: RTL and testbench

- Flow-control wrapper and sequencer for the fixed-latency, always-enabled GEMM datapath (32x32 matrices of 32-bit words, flattened row-major; element [r][c] at bits [(r*32+c)*32 +: 32]).
- Accepts matrix-pair jobs on a valid/ready port, issues them to the datapath, and tracks in-flight jobs with a valid/tag shift register.
- Captures each result exactly LATENCY edges after issue into a result FIFO, then presents it on a valid/ready port.
- Credit accounting ensures no result is ever dropped under output backpressure.

---
 rtl/gemm_issue_ctrl.sv | 91 +++++++++
 tb/tb_gemm_issue_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gemm_issue_ctrl.sv
// Issue/capture sequencer around a fixed-latency GEMM datapath: valid/ready job intake,
// in-flight tracking shift register, credit-limited result FIFO, valid/ready result port.
module gemm_issue_ctrl #(
  parameter int W          = 32768,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 5,
  parameter int TAG_W      = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [W-1:0]     pipe_arg0,
  output logic [W-1:0]     pipe_arg1,
  input  logic [W-1:0]     pipe_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_c,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [LATENCY-1:0]            vld_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;
  logic [CW-1:0]                 inflight_cnt, fifo_cnt;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [W-1:0]                  mem_c   [FIFO_DEPTH];
  logic [TAG_W-1:0]              mem_tag [FIFO_DEPTH];
  logic                          fire, cap, pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pipe_arg0 = in_a;
  assign pipe_arg1 = in_b;

  // Credit check on registered counts only: every issued job already owns a FIFO slot.
  assign in_ready  = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH);
  assign fire      = in_valid & in_ready;
  assign cap       = vld_pipe[LATENCY-1];
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign busy      = (inflight_cnt != '0) | (fifo_cnt != '0);
  assign out_c     = mem_c[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      done_count   <= '0;
    end else begin
      vld_pipe[0] <= fire;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (fire && !cap)      inflight_cnt <= inflight_cnt + CW'(1);
      else if (!fire && cap) inflight_cnt <= inflight_cnt - CW'(1);
      if (cap && !pop)       fifo_cnt <= fifo_cnt + CW'(1);
      else if (!cap && pop)  fifo_cnt <= fifo_cnt - CW'(1);
      if (cap) wr_ptr <= wrap_inc(wr_ptr);
      if (pop) begin
        rd_ptr     <= wrap_inc(rd_ptr);
        done_count <= done_count + CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset; validity lives in vld_pipe and fifo_cnt.
  always_ff @(posedge clk) begin
    tag_pipe[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    if (cap) begin
      mem_c[wr_ptr]   <= pipe_out;
      mem_tag[wr_ptr] <= tag_pipe[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (int'(inflight_cnt) + int'(fifo_cnt) <= FIFO_DEPTH);
  end
endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// Bench for gemm_issue_ctrl: behavioural GEMM datapath plus a job-queue reference model
// (issue time, expected product, tag) checked every cycle.
module tb_gemm_issue_ctrl;
  localparam int W = 32768, L = 3, D = 5, TW = 8, CNTW = 32;

  logic          clk = 0, rst = 0;
  logic          in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [W-1:0]  in_a = '0, in_b = '0, pipe_arg0, pipe_arg1, pipe_out, out_c;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [CNTW-1:0] done_count;

  gemm_issue_ctrl #(.W(W), .LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .pipe_arg0(pipe_arg0), .pipe_arg1(pipe_arg1), .pipe_out(pipe_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag),
    .busy(busy), .done_count(done_count));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] matmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] am [1024];
    logic [31:0] bm [1024];
    logic [W-1:0] r;
    logic [31:0] s;
    for (int i = 0; i < 1024; i++) begin
      am[i] = a[i*32 +: 32];
      bm[i] = b[i*32 +: 32];
    end
    r = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        s = '0;
        for (int k = 0; k < 32; k++) s += am[i*32+k] * bm[k*32+j];
        r[(i*32+j)*32 +: 32] = s;
      end
    return r;
  endfunction

  // Datapath stand-in: computes every cycle, result stable LATENCY edges after sampling.
  logic [W-1:0] dp [L];
  always @(posedge clk) begin
    dp[0] <= matmul(pipe_arg0, pipe_arg1);
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign pipe_out = dp[L-1];

  function automatic logic [W-1:0] rand_mat();
    logic [W-1:0] m;
    for (int i = 0; i < 1024; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [W-1:0] ident(input int k);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[(i*33)*32 +: 32] = 32'(k);
    return m;
  endfunction

  typedef struct {
    logic [W-1:0]  c;
    logic [TW-1:0] tag;
    int            t;
  } job_t;

  job_t        q[$];
  int          cyc = 0;
  int unsigned pops = 0;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A job's result is visible once its capture edge (issue edge + L) has passed.
  function automatic bit vis();
    return q.size() > 0 && q[0].t + L <= cyc;
  endfunction

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 1024; i++) if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
    return 0;
  endfunction

  task automatic check_outputs();
    logic [W-1:0] ec;
    int idx;
    chk("in_ready", 64'(in_ready), 64'(q.size() < D));
    chk("out_valid", 64'(out_valid), 64'(vis()));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("done_count", 64'(done_count), 64'(pops));
    if (vis()) begin
      ec  = q[0].c;
      idx = first_diff(out_c, ec);
      chk("out_c", {32'(idx), out_c[idx*32 +: 32]}, {32'(idx), ec[idx*32 +: 32]});
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
    end
  endtask

  task automatic step();
    bit f, p;
    f = in_valid && (q.size() < D);
    p = out_ready && vis();
    @(posedge clk);
    cyc++;
    if (p) begin
      void'(q.pop_front());
      pops++;
    end
    if (f) q.push_back('{matmul(in_a, in_b), in_tag, cyc});
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit rdy, input logic [TW-1:0] tag,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = v;
    out_ready = rdy;
    in_tag    = tag;
    in_a      = a;
    in_b      = b;
    step();
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) drive(0, rdy, 8'($urandom), rand_mat(), rand_mat());
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_count", 64'(done_count), 64'd0);
    q.delete();
    pops = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [W-1:0] a2, b2;
    #2;
    do_reset();
    idle(1, 2);

    // single 2x2 job
    a2 = '0; b2 = '0;
    foreach (a2[i]) begin end
    for (int i = 0; i < 4; i++) begin
      a2[(i / 2 * 32 + i % 2) * 32 +: 32] = 32'd1;
      b2[(i / 2 * 32 + i % 2) * 32 +: 32] = 32'd2;
    end
    drive(1, 1, 8'h11, a2, b2);
    idle(1, 3);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_c00", 64'(out_c[31:0]), 64'd4);
    chk("single_c01", 64'(out_c[63:32]), 64'd4);
    chk("single_c10", 64'(out_c[1055:1024]), 64'd4);
    chk("single_c11", 64'(out_c[1087:1056]), 64'd4);
    chk("single_c02", 64'(out_c[95:64]), 64'd0);
    chk("single_tag", 64'(out_tag), 64'h11);
    idle(1, 2);
    chk("single_done", 64'(done_count), 64'd1);

    // back-to-back identity*k jobs
    for (int k = 1; k <= 8; k++) drive(1, 1, 8'(k - 1), ident(k), ident(1));
    idle(1, 6);

    // full backpressure, then drain
    for (int i = 0; i < 9; i++) drive(1, 0, 8'(8'h40 + i), rand_mat(), rand_mat());
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    idle(1, 8);

    // bubbles: fire on cycles 0, 2, 5
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 2 || i == 5) drive(1, 1, 8'(i == 0 ? 1 : (i == 2 ? 2 : 3)), rand_mat(), rand_mat());
      else idle(1, 1);
    end
    idle(1, 2);

    // reset with 2 buffered and 2 in flight
    for (int i = 0; i < 4; i++) drive(1, 0, 8'(8'h80 + i), rand_mat(), rand_mat());
    idle(0, 1);
    do_reset();
    idle(1, 10);
    drive(1, 1, 8'h55, rand_mat(), rand_mat());
    idle(1, 6);

    // stall/hold: out_ready 0,0,1 while out_valid
    drive(1, 0, 8'h66, rand_mat(), rand_mat());
    idle(0, 3);
    idle(0, 2);
    idle(1, 3);

    // randomized traffic
    for (int i = 0; i < 250; i++)
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65, 8'($urandom),
            rand_mat(), rand_mat());
    idle(1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
